mul_share_arbiter: RTL and testbench
====================================

# mul_share_arbiter

Shares one serial Booth multiplier between several requesters in the convolution datapath. It is a round-robin arbiter plus multiply sequencer: it grants one requester at a time, captures that requester's pixel operand and kernel coefficient, and runs a multi-cycle signed multiply. It returns the exact 37-bit product with a one-cycle done pulse to the granted requester. Typical requesters are the layer-0 convolution engine and a bias/normalisation engine.

## Interface
- NREQ, 2 — number of requesters, legal range 2..4.
- clk  in  1 — clock, rising edge.
- reset  in  1 — synchronous, active-high.
- req  in  NREQ — request per requester; held high with stable operands until its gnt is seen.
- a_data  in  NREQ*20 — signed 20-bit multiplicand per requester; requester i uses bits [20i+19:20i].
- b_coef  in  NREQ*17 — signed 17-bit coefficient per requester; requester i uses bits [17i+16:17i].
- gnt  out  NREQ — one-hot, one-cycle pulse: operands were captured.
- done  out  NREQ — one-hot, one-cycle pulse: product is valid.
- product  out  37 — signed result; valid only while done is non-zero, holds its value otherwise.
- busy  out  1 — high in RUN and DONE.

## Operation
- States:
  - IDLE: arbitrate.
  - RUN: iterate.
  - DONE: present the result and arbitrate.
- Arbitration happens at any clock edge in IDLE or DONE with req≠0.
  - Pick the first set req bit starting at rr_ptr and wrapping upward.
  - Register the winner index, a_data and b_coef.
  - Assert gnt[winner] in the next cycle.
  - Enter RUN; set rr_ptr to winner+1, wrapping to 0 after NREQ-1.
- From IDLE or DONE with req=0, go to / stay in IDLE.
- req is ignored throughout RUN. The requester drops req after seeing gnt. A req still high in the DONE cycle counts as a new request.
- RUN runs a radix-2 Booth multiply over a 38-bit accumulator {17-bit upper, 20-bit multiplicand, guard bit}.
  - Each iteration inspects bits [1:0]: 01 → add b_coef; 10 → subtract b_coef.
  - Then arithmetic-shift right by 1.
  - There are 20 iterations, counted 0..19; after iteration 19, go to DONE.
- DONE lasts exactly 1 cycle.
  - done[winner]=1; product = accumulator[37:1], the exact signed a×b.
- Width rules: no saturation, no rounding. Full range holds; the maximum magnitude is (-2^19)(-2^16)=2^35.
- Reset values:
  - gnt=0, done=0, product=0, busy=0.
  - State IDLE, rr_ptr=0, iteration counter 0.
- Reset asserted mid-RUN aborts the multiply; no done pulse is ever issued for it.

## Timing
- Request sampled at edge E0: gnt high in cycle E0+1, which is also the first RUN cycle.
- done high in cycle E0+21 (radix-2).
- Back-to-back throughput: the next grant is sampled at the DONE edge. One product per 21 cycles, no idle gap.
- The same requester may be done (result) and granted (new capture) at the edge leaving DONE.
- rr_ptr guarantees each of NREQ continuously requesting masters is served within NREQ transactions.

## Configuration
- MUL_RADIX4_EN defined:
  - RUN uses radix-4 Booth on a sign-extended 22-bit multiplier, inspecting 3 bits per step (±b, ±2b) and shifting right by 2.
  - 10 iterations (0..9); done in cycle E0+11.
  - Products are bit-identical to radix-2.
- Undefined: radix-2, 20 iterations, as described above.

## Test plan
- Reset, then req=01 with a=0x00001, b=0x0A89E → gnt=01 at cycle 1, done=01 at cycle 21 (11 with radix-4), product=0x000000A89E.
- a=0x7FFFF, b=0x10000 → product=0x1800010000 (−34359672832); a=0x80000, b=0x10000 → product=0x0800000000.
- req=11 held from reset, each requester dropping req for one cycle after its gnt → grants alternate 0,1,0,1. Each done goes to the matching index; no idle cycle between DONE and the next RUN.
- req[1] raised during RUN of requester 0 → ignored until DONE; granted at the DONE edge, gnt[1] in the cycle right after done[0].
- reset pulsed at RUN iteration 7 → no done pulse, busy=0, product=0. A following request yields a correct result, and rr_ptr restarts at 0.
- Random 1000 operand pairs across NREQ=4, compared against a signed reference multiply → all products exact. Each gnt has exactly one done.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one serial signed Booth multiplier (20b x 17b -> 37b).
// Define MUL_RADIX4_EN for the radix-4 sequencer (10 iterations instead of 20).
module mul_share_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*20-1:0]   a_data,
  input  logic [NREQ*17-1:0]   b_coef,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [36:0]          product,
  output logic                 busy
);

  localparam int IDX_W = (NREQ > 2) ? 2 : 1;
  localparam logic [IDX_W:0]   NREQ_V   = (IDX_W+1)'(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

`ifdef MUL_RADIX4_EN
  // {18-bit upper, 22-bit sign-extended multiplier, guard}
  localparam int ACC_W    = 41;
  localparam int PROD_LSB = 3;
  localparam logic [4:0] LAST_ITER = 5'd9;
`else
  // {17-bit upper, 20-bit multiplier, guard}
  localparam int ACC_W    = 38;
  localparam int PROD_LSB = 1;
  localparam logic [4:0] LAST_ITER = 5'd19;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

`ifdef MUL_RADIX4_EN
  function automatic logic [ACC_W-1:0] booth_step(input logic [ACC_W-1:0] acc,
                                                  input logic [16:0]      b);
    logic [19:0] up;
    logic [19:0] bx;
    logic [19:0] sum;
    up  = {{2{acc[40]}}, acc[40:23]};
    bx  = {{3{b[16]}}, b};
    case (acc[2:0])
      3'b001, 3'b010: sum = up + bx;
      3'b011:         sum = up + (bx << 1);
      3'b100:         sum = up - (bx << 1);
      3'b101, 3'b110: sum = up - bx;
      default:        sum = up;
    endcase
    return {sum, acc[22:2]};
  endfunction

  function automatic logic [ACC_W-1:0] booth_init(input logic [19:0] a);
    return {18'd0, {2{a[19]}}, a, 1'b0};
  endfunction
`else
  // The add is one bit wider than the upper field so -(-2^16) cannot overflow before the shift.
  function automatic logic [ACC_W-1:0] booth_step(input logic [ACC_W-1:0] acc,
                                                  input logic [16:0]      b);
    logic [17:0] up;
    logic [17:0] bx;
    logic [17:0] sum;
    up  = {acc[37], acc[37:21]};
    bx  = {b[16], b};
    case (acc[1:0])
      2'b01:   sum = up + bx;
      2'b10:   sum = up - bx;
      default: sum = up;
    endcase
    return {sum, acc[20:1]};
  endfunction

  function automatic logic [ACC_W-1:0] booth_init(input logic [19:0] a);
    return {17'd0, a, 1'b0};
  endfunction
`endif

  state_t             state_r, state_next_s;
  logic [IDX_W-1:0]   rr_ptr_r, cur_r;
  logic [4:0]         iter_r;
  logic [ACC_W-1:0]   acc_r, acc_step_s;
  logic [16:0]        b_r;
  logic [NREQ-1:0]    gnt_r, done_r;
  logic [36:0]        product_r;
  logic               busy_r;

  logic [NREQ-1:0]    rot_s;
  logic [IDX_W-1:0]   off_s, winner_s, rr_next_s;
  logic [IDX_W:0]     wsum_s;
  logic               found_s, arb_s;
  logic [19:0]        sel_a_s;
  logic [16:0]        sel_b_s;

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    rot_s   = NREQ'({req, req} >> rr_ptr_r);
    found_s = |req;
    off_s   = '0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      off_s = rot_s[o] ? IDX_W'(o) : off_s;
    end
    wsum_s = {1'b0, rr_ptr_r} + {1'b0, off_s};
    if (wsum_s >= NREQ_V) begin
      winner_s = IDX_W'(wsum_s - NREQ_V);
    end else begin
      winner_s = wsum_s[IDX_W-1:0];
    end
    rr_next_s = (winner_s == LAST_IDX) ? '0 : winner_s + IDX_W'(1);
    arb_s     = found_s && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel_a_s = sel_a_s | (a_data[k*20 +: 20] & {20{winner_s == IDX_W'(k)}});
      sel_b_s = sel_b_s | (b_coef[k*17 +: 17] & {17{winner_s == IDX_W'(k)}});
    end
    acc_step_s = booth_step(acc_r, b_r);
  end

  // Sequencer next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: state_next_s = found_s ? ST_RUN : ST_IDLE;
      ST_RUN:           state_next_s = (iter_r == LAST_ITER) ? ST_DONE : ST_RUN;
      default:          state_next_s = ST_IDLE;
    endcase
  end

  // State register; busy follows the state it is entering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
    end
  end

  // Capture, iterate and present the product.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r  <= '0;
      cur_r     <= '0;
      iter_r    <= 5'd0;
      acc_r     <= '0;
      b_r       <= 17'd0;
      gnt_r     <= '0;
      done_r    <= '0;
      product_r <= 37'd0;
    end else begin
      gnt_r  <= '0;
      done_r <= '0;
      if (arb_s) begin
        gnt_r    <= ONE_HOT0 << winner_s;
        cur_r    <= winner_s;
        rr_ptr_r <= rr_next_s;
        acc_r    <= booth_init(sel_a_s);
        b_r      <= sel_b_s;
        iter_r   <= 5'd0;
      end else if (state_r == ST_RUN) begin
        acc_r  <= acc_step_s;
        iter_r <= iter_r + 5'd1;
        if (iter_r == LAST_ITER) begin
          done_r    <= ONE_HOT0 << cur_r;
          product_r <= acc_step_s[PROD_LSB +: 37];
        end
      end
    end
  end

  assign gnt     = gnt_r;
  assign done    = done_r;
  assign product = product_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter (NREQ=4): directed steps plus random traffic against a
// transaction-level model (round-robin pick, fixed latency, signed multiply).
module tb_mul_share_arbiter;

  localparam int NREQ = 4;
`ifdef MUL_RADIX4_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 21;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [19:0]       a_v [NREQ];
  logic [16:0]       b_v [NREQ];
  logic [NREQ*20-1:0] a_data;
  logic [NREQ*17-1:0] b_coef;
  logic [NREQ-1:0]   gnt, done;
  logic [36:0]       product;
  logic              busy;

  int n_assert = 0;
  int n_fail   = 0;
  int rr_m     = 0;

  mul_share_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req(req), .a_data(a_data), .b_coef(b_coef),
    .gnt(gnt), .done(done), .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    a_data = '0;
    b_coef = '0;
    for (int k = 0; k < NREQ; k++) begin
      a_data[k*20 +: 20] = a_v[k];
      b_coef[k*17 +: 17] = b_v[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [36:0] ref_mul(input logic [19:0] a, input logic [16:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[36:0];
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [19:0] rand_a();
    case ($urandom_range(0, 7))
      0:       return 20'h80000;
      1:       return 20'h7FFFF;
      default: return 20'($urandom);
    endcase
  endfunction

  function automatic logic [16:0] rand_b();
    case ($urandom_range(0, 7))
      0:       return 17'h10000;
      1:       return 17'h0FFFF;
      default: return 17'($urandom);
    endcase
  endfunction

  // One transaction: grant at the next edge, done LAT edges after the sampling edge.
  task automatic serve(input bit rearm, input int raise_idx);
    int w;
    logic [36:0] expv;
    w = pick(req, rr_m);
    if (w < 0) begin
      check("serve_no_request", 64'(req), 64'd1);
      return;
    end
    expv = ref_mul(a_v[w], b_v[w]);
    tick();
    check("gnt", 64'(gnt), 64'(onehot(w)));
    check("busy_grant", 64'(busy), 64'd1);
    check("done_at_grant", 64'(done), 64'd0);
    rr_m   = (w + 1) % NREQ;
    req[w] = 1'b0;
    a_v[w] = rand_a();
    b_v[w] = rand_b();
    for (int c = 2; c < LAT; c++) begin
      tick();
      if (c == 2 && rearm) req[w] = 1'b1;
      if (c == 5 && raise_idx >= 0) req[raise_idx] = 1'b1;
      check("run_done", 64'(done), 64'd0);
      check("run_gnt", 64'(gnt), 64'd0);
      check("run_busy", 64'(busy), 64'd1);
    end
    tick();
    check("done", 64'(done), 64'(onehot(w)));
    check("product", 64'(product), 64'(expv));
    check("busy_done", 64'(busy), 64'd1);
    check("gnt_done", 64'(gnt), 64'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rr_m  = 0;
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      a_v[k] = 20'd0;
      b_v[k] = 17'd0;
    end
    tick();
    tick();
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    rr_m  = 0;

    // Basic product and latency.
    a_v[0] = 20'h00001; b_v[0] = 17'h0A89E; req[0] = 1'b1;
    serve(1'b0, -1);
    check("basic_const", 64'(product), 64'h00_0000_A89E);

    // Extreme operands.
    a_v[0] = 20'h7FFFF; b_v[0] = 17'h10000; req[0] = 1'b1;
    serve(1'b0, -1);
    check("maxneg_const", 64'(product), 64'h18_0001_0000);
    a_v[0] = 20'h80000; b_v[0] = 17'h10000; req[0] = 1'b1;
    serve(1'b0, -1);
    check("minmin_const", 64'(product), 64'h08_0000_0000);
    req = '0;
    tick();
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_product_hold", 64'(product), 64'h08_0000_0000);

    // Two continuous requesters from reset alternate with no idle gap.
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      a_v[k] = rand_a(); b_v[k] = rand_b();
    end
    req = 4'b0011;
    for (int t = 0; t < 4; t++) begin
      serve(1'b1, -1);
    end
    req = '0;
    tick();
    check("alt_end_busy", 64'(busy), 64'd0);

    // Request raised mid-RUN waits for the DONE edge.
    apply_reset();
    a_v[0] = rand_a(); b_v[0] = rand_b();
    a_v[1] = rand_a(); b_v[1] = rand_b();
    req = 4'b0001;
    serve(1'b0, 1);
    serve(1'b0, -1);
    tick();
    check("late_end_busy", 64'(busy), 64'd0);

    // Reset in the middle of a multiply.
    a_v[2] = rand_a(); b_v[2] = rand_b();
    req = 4'b0100;
    tick();
    check("abort_gnt", 64'(gnt), 64'b0100);
    req = '0;
    for (int k = 0; k < 7; k++) tick();
    apply_reset();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_product", 64'(product), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    for (int k = 0; k < LAT + 4; k++) begin
      tick();
      check("abort_no_done", 64'(done), 64'd0);
    end
    a_v[0] = rand_a(); b_v[0] = rand_b();
    a_v[1] = rand_a(); b_v[1] = rand_b();
    req = 4'b0011;
    serve(1'b0, -1);
    req = '0;
    tick();

    // Random traffic across all four requesters.
    for (int t = 0; t < 1000; t++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!req[k] && ($urandom_range(0, 1) == 1)) begin
          a_v[k] = rand_a();
          b_v[k] = rand_b();
          req[k] = 1'b1;
        end
      end
      if (req == '0) req[$urandom_range(0, NREQ - 1)] = 1'b1;
      serve(1'b0, -1);
    end
    req = '0;
    tick();
    tick();
    check("final_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
